// File: rtl/seq_detector_param.sv
// Serial pattern detector with a run-time programmable pattern and length.
// It supports overlapping and non-overlapping matches and keeps a saturating match counter.
module seq_detector_param #(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic             in_valid,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic             overlap,
  input  logic             clr_count,
  output logic             out,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] shifted;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] eff_len;
  logic             enough_bits;
  logic             match;

  // NOTE: every signal written here gets a value before any condition, so no latch can form.
  always_comb begin
    eff_len     = (pat_len > PAT_W_L) ? PAT_W_L : pat_len;
    shifted     = {hist[PAT_W-2:0], data_in};
    len_mask    = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(eff_len));
    end
    // The incoming bit counts toward fill, hence the +1 in a widened compare.
    enough_bits = ({1'b0, fill} + (LEN_W + 1)'(1)) >= {1'b0, eff_len};
    match       = in_valid && (eff_len != '0) && enough_bits &&
                  (((shifted ^ pattern) & len_mask) == '0);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist        <= '0;
      fill        <= '0;
      out         <= 1'b0;
      match_count <= '0;
    end else begin
      out <= match;
      if (in_valid) begin
        hist <= shifted;
        if (match && !overlap) begin
          fill <= '0;
        end else if (fill != PAT_W_L) begin
          fill <= fill + LEN_W'(1);
        end
      end
      // A clear wins over a coincident match; the pulse on out still happens.
      if (clr_count) begin
        match_count <= '0;
      end else if (match && (match_count != CNT_MAX)) begin
        match_count <= match_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a bit-list reference model pushes expected
// out/match_count into a scoreboard queue, which is popped one edge later and compared.
module tb_seq_detector_param;

  localparam int PAT_W = 8;
  localparam int CNT_W = 8;
  localparam int LEN_W = $clog2(PAT_W + 1);

  typedef struct {
    logic             out;
    logic [CNT_W-1:0] count;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             data_in;
  logic             in_valid;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] pat_len;
  logic             overlap;
  logic             clr_count;
  logic             out;
  logic [CNT_W-1:0] match_count;

  exp_t sb[$];
  bit   model_bits[$];
  int   model_count = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   checks      = 0;

  seq_detector_param #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .in_valid    (in_valid),
    .pattern     (pattern),
    .pat_len     (pat_len),
    .overlap     (overlap),
    .clr_count   (clr_count),
    .out         (out),
    .match_count (match_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Reference: keep the accepted bits since the last restart and compare the newest L of them.
  function automatic exp_t model_step(input bit d, input bit v, input bit c, input bit r);
    exp_t e;
    bit   m;
    int   l;
    m = 1'b0;
    if (r) begin
      model_bits.delete();
      model_count = 0;
    end else begin
      if (v) begin
        model_bits.push_back(d);
        l = (int'(pat_len) > PAT_W) ? PAT_W : int'(pat_len);
        if (l != 0 && model_bits.size() >= l) begin
          m = 1'b1;
          for (int k = 0; k < l; k++)
            if (model_bits[model_bits.size() - 1 - k] != pattern[k]) m = 1'b0;
        end
        if (model_bits.size() > PAT_W) void'(model_bits.pop_front());
        if (m && !overlap) model_bits.delete();
      end
      if (c) model_count = 0;
      else if (m && model_count < (2 ** CNT_W - 1)) model_count++;
    end
    e.out   = m;
    e.count = CNT_W'(model_count);
    return e;
  endfunction

  task automatic step(input bit d, input bit v, input bit c = 1'b0, input bit r = 1'b0);
    exp_t e;
    data_in   = d;
    in_valid  = v;
    clr_count = c;
    rst       = r;
    sb.push_back(model_step(d, v, c, r));
    vectors++;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("out", 32'(out), 32'(e.out));
      check("match_count", 32'(match_count), 32'(e.count));
    end
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; data_in = 1'b0; in_valid = 1'b0; clr_count = 1'b0;
    pattern = 8'h0B; pat_len = 4'd4; overlap = 1'b1;

    do_reset();
    check("reset_out", 32'(out), 32'd0);
    check("reset_count", 32'(match_count), 32'd0);

    // Overlapping 1011 on 1,0,1,1,0,1,1: pulses after bits 4 and 7.
    send_bits(16'b1011011, 7);
    check("overlap_count", 32'(match_count), 32'd2);

    // Non-overlapping: single pulse.
    do_reset();
    overlap = 1'b0;
    send_bits(16'b1011011, 7);
    check("nonoverlap_count", 32'(match_count), 32'd1);

    // Reset mid-pattern discards progress.
    do_reset();
    overlap = 1'b1;
    send_bits(16'b101, 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("midreset_out", 32'(out), 32'd0);
    step(1'b1, 1'b1);
    check("midreset_count", 32'(match_count), 32'd0);

    // in_valid gaps of 0..3 cycles inside the sequence.
    do_reset();
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    check("gap_count", 32'(match_count), 32'd1);

    // pat_len=2, pattern 11: back-to-back pulses; then pat_len=0 disables.
    do_reset();
    pattern = 8'h03; pat_len = 4'd2;
    send_bits(16'b1111, 4);
    check("len2_count", 32'(match_count), 32'd3);
    pat_len = 4'd0;
    send_bits(16'b1111, 4);
    check("len0_count", 32'(match_count), 32'd3);

    // pat_len beyond PAT_W clamps to PAT_W.
    do_reset();
    pattern = 8'hA5; pat_len = 4'd9;
    send_bits(16'hA5, 8);
    check("clamp_count", 32'(match_count), 32'd1);

    // Saturation after 300 matches, then clear on a match edge.
    do_reset();
    pattern = 8'h03; pat_len = 4'd2;
    for (int i = 0; i < 301; i++) step(1'b1, 1'b1);
    check("sat_count", 32'(match_count), 32'd255);
    step(1'b1, 1'b1, 1'b1);
    check("clr_out", 32'(out), 32'd1);
    check("clr_count", 32'(match_count), 32'd0);
    step(1'b1, 1'b1);
    check("after_clr_count", 32'(match_count), 32'd1);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
